// File: rtl/tsu_queue_reader.sv
// tsu_queue_reader
// Drains the tsu timestamp queue read port into a 2-entry output buffer and
// presents the entries on a valid/ready stream. Single clock domain (q_rd_clk).
//
// Ports:
//   q_rd_clk   - queue read clock
//   rst        - synchronous active-high reset
//   enable     - drain enable; 0 stops new reads
//   flush      - discards buffered entries and any in-flight read
//   q_rd_stat  - tsu queue entry count (0 = empty)
//   q_rd_en    - single-cycle pop strobe to the tsu queue
//   q_rd_data  - queue data, valid the cycle after q_rd_en
//   out_valid  - buffer head holds an entry
//   out_ready  - consumer accepts the head entry
//   out_data   - head entry (holds last value while empty)
//   buf_level  - buffer occupancy 0..2
//   rd_cnt     - saturating pop counter
//
// Build option: TSU_QRD_CNT_EN enables the rd_cnt counter; otherwise rd_cnt is 0.

module tsu_queue_reader #(
    parameter int STAT_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              q_rd_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              flush,
    input  logic [STAT_W-1:0] q_rd_stat,
    output logic              q_rd_en,
    input  logic [DATA_W-1:0] q_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        buf_level,
    output logic [15:0]       rd_cnt
);

    logic              rd_en_q, rd_en_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        level_q, level_d;
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              pop;
    logic [2:0]        pending;

    always_comb begin
        pending    = {1'b0, level_q} + {2'b00, inflight_q};
        pop        = (level_q != 2'd0) && out_ready;
        // At most one read outstanding; the idle gap also lets q_rd_stat
        // catch up with the previous pop before the next decision.
        rd_en_d    = enable && !flush && (q_rd_stat != '0) && !inflight_q &&
                     !rd_en_q && (pending < 3'd2);
        inflight_d = rd_en_q && !flush;

        mem_d      = mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        level_d    = level_q;
        out_data_d = out_data_q;

        if (flush) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            level_d = 2'd0;
        end else begin
            if (inflight_q) begin
                mem_d[tail_q] = q_rd_data;
                tail_d        = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            level_d = level_q + {1'b0, inflight_q} - {1'b0, pop};
            // Registered head view: holds the last entry once the buffer empties.
            if (level_d != 2'd0) begin
                out_data_d = mem_d[head_d];
            end
        end
    end

    always_ff @(posedge q_rd_clk) begin
        if (rst) begin
            rd_en_q    <= 1'b0;
            inflight_q <= 1'b0;
            level_q    <= 2'd0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            out_data_q <= '0;
        end else begin
            rd_en_q    <= rd_en_d;
            inflight_q <= inflight_d;
            level_q    <= level_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            mem_q      <= mem_d;
            out_data_q <= out_data_d;
        end
    end

    assign q_rd_en   = rd_en_q;
    assign out_valid = (level_q != 2'd0);
    assign out_data  = out_data_q;
    assign buf_level = level_q;

`ifdef TSU_QRD_CNT_EN
    logic [15:0] rd_cnt_q;

    // Cleared by rst only; flush leaves the count intact.
    always_ff @(posedge q_rd_clk) begin
        if (rst) begin
            rd_cnt_q <= 16'h0000;
        end else if (rd_en_q && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_q <= rd_cnt_q + 16'h0001;
        end
    end

    assign rd_cnt = rd_cnt_q;
`else
    assign rd_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_tsu_queue_reader.sv
module tb_tsu_queue_reader;

    logic        q_rd_clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  q_rd_stat = 8'd3;
    logic        q_rd_en;
    logic [63:0] q_rd_data = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [1:0]  buf_level;
    logic [15:0] rd_cnt;

    tsu_queue_reader dut (
        .q_rd_clk (q_rd_clk),
        .rst      (rst),
        .enable   (enable),
        .flush    (flush),
        .q_rd_stat(q_rd_stat),
        .q_rd_en  (q_rd_en),
        .q_rd_data(q_rd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .buf_level(buf_level),
        .rd_cnt   (rd_cnt)
    );

    always #5 q_rd_clk = ~q_rd_clk;

    int n_checks = 0;
    int n_errors = 0;

    // tsu queue contents and reference model of the reader
    logic [63:0] tsu_q[$];
    logic [63:0] exp_q[$];
    logic        m_rd_en = 1'b0;
    logic        m_inflight = 1'b0;
    logic [63:0] m_last = 64'd0;
    int unsigned m_cnt = 0;
    int          pulses = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, then drive inputs for the
    // next rising edge and advance the reference model across it.
    task automatic cycle(input logic en, input logic fl, input logic rdy, input logic rs);
        logic nxt;
        @(negedge q_rd_clk);
        check_val("q_rd_en", q_rd_en, m_rd_en);
        check_val("out_valid", out_valid, exp_q.size() != 0);
        check_val("buf_level", buf_level, exp_q.size());
        check_val("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : m_last);
`ifdef TSU_QRD_CNT_EN
        check_val("rd_cnt", rd_cnt, m_cnt);
`else
        check_val("rd_cnt", rd_cnt, 64'd0);
`endif
        if (q_rd_en) begin
            pulses++;
            q_rd_data = (tsu_q.size() != 0) ? tsu_q.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
        end else if (!m_inflight) begin
            q_rd_data = {$urandom, $urandom};
        end
        rst       = rs;
        enable    = en;
        flush     = fl;
        out_ready = rdy;
        q_rd_stat = (tsu_q.size() > 255) ? 8'd255 : 8'(tsu_q.size());

        if (rs) begin
            exp_q.delete();
            m_rd_en    = 1'b0;
            m_inflight = 1'b0;
            m_last     = 64'd0;
            m_cnt      = 0;
        end else begin
            nxt = en && !fl && (q_rd_stat != 0) && !m_inflight && !m_rd_en &&
                  ((exp_q.size() + int'(m_inflight)) < 2);
            if (fl) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
                if (m_inflight) exp_q.push_back(q_rd_data);
                if (exp_q.size() != 0) m_last = exp_q[0];
            end
            if (m_rd_en && m_cnt != 32'd65535) m_cnt++;
            m_inflight = m_rd_en && !fl;
            m_rd_en    = nxt;
        end
    endtask

    initial begin
        bit found;

        // reset held two cycles with a non-empty queue
        repeat (3) tsu_q.push_back({$urandom, $urandom});
        cycle(1, 0, 1, 1);
        cycle(1, 0, 1, 1);

        // basic drain of a single entry
        tsu_q.delete();
        tsu_q.push_back(64'h0000_0001_2345_6789);
        pulses = 0;
        repeat (8) cycle(1, 0, 1, 0);
        check_val("basic_pulses", pulses, 1);

        // back-pressure: only two reads fit the buffer
        pulses = 0;
        repeat (5) tsu_q.push_back({$urandom, $urandom});
        repeat (20) cycle(1, 0, 0, 0);
        check_val("bp_pulses", pulses, 2);
        check_val("bp_level", buf_level, 2);
        repeat (30) cycle(1, 0, 1, 0);
        check_val("bp_total", pulses, 5);

        // empty queue: never strobe
        pulses = 0;
        repeat (20) cycle(1, 0, 1, 0);
        check_val("empty_pulses", pulses, 0);

        // flush with one buffered entry and one read in flight
        repeat (4) tsu_q.push_back({$urandom, $urandom});
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            cycle(1, 0, 0, 0);
            if (exp_q.size() == 1 && m_inflight) found = 1;
        end
        check_val("flush_setup", found, 1);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        check_val("flush_level", buf_level, 0);
        check_val("flush_valid", out_valid, 0);
        repeat (20) cycle(1, 0, 1, 0);

        // capture and pop in the same cycle
        tsu_q.delete();
        repeat (3) tsu_q.push_back({$urandom, $urandom});
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            cycle(1, 0, 0, 0);
            if (exp_q.size() == 1 && m_inflight) found = 1;
        end
        check_val("simul_setup", found, 1);
        cycle(1, 0, 1, 0);
        cycle(1, 0, 0, 0);
        check_val("simul_level", buf_level, 1);
        repeat (20) cycle(1, 0, 1, 0);

        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            if (tsu_q.size() < 3 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) tsu_q.push_back({$urandom, $urandom});
            end
            cycle($urandom_range(0, 7) != 0, $urandom_range(0, 24) == 0,
                  1'($urandom), $urandom_range(0, 199) == 0);
        end
        cycle(1, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
